// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - runtime-programmable serial pattern detector with Mealy match flag
// Optional saturating match counter enabled by SEQ_DETECT_CNT_EN.
module seq_detect_prog #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1101),
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             pat_load,
    input  logic             overlap,
    output logic             y
`ifdef SEQ_DETECT_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0] pat_reg;
    logic [PAT_W-2:0] hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0] window;

    // Candidate window: stored history plus the bit arriving this cycle.
    assign window = {hist, din};

    always_comb begin
        y = din_valid && !pat_load && (fill == FILL_MAX) && (window == pat_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_reg <= RST_PAT;
            hist    <= '0;
            fill    <= '0;
        end else if (pat_load) begin
            pat_reg <= pat_in;
            fill    <= '0;
        end else if (din_valid) begin
            hist <= window[PAT_W-2:0];
            // Non-overlapping mode forces a full refill before the next match.
            if (y && !overlap) begin
                fill <= '0;
            end else if (fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
        end
    end

`ifdef SEQ_DETECT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
        end else if (y && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb/tb_seq_detect_prog.sv - directed self-checking bench for seq_detect_prog
module tb_seq_detect_prog;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       pat_load = 1'b0;
    logic       overlap = 1'b1;
    logic       y;
    logic [1:0] pat_in2 = 2'b00;
    logic       pat_load2 = 1'b0;
    logic       y2;
`ifdef SEQ_DETECT_CNT_EN
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_prog #(.PAT_W(4), .RST_PAT(4'b1101), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .pat_in(pat_in), .pat_load(pat_load), .overlap(overlap), .y(y)
`ifdef SEQ_DETECT_CNT_EN
        , .match_cnt(match_cnt)
`endif
    );

    seq_detect_prog #(.PAT_W(2), .RST_PAT(2'b11), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .pat_in(pat_in2), .pat_load(pat_load2), .overlap(overlap), .y(y2)
`ifdef SEQ_DETECT_CNT_EN
        , .match_cnt(match_cnt2)
`endif
    );

    task automatic drive(input logic d, input logic v, input logic ld,
                         output logic oy, output logic oy2);
        @(negedge clk);
        din = d;
        din_valid = v;
        pat_load = ld;
        #1;
        oy = y;
        oy2 = y2;
    endtask

    task automatic idle();
        @(negedge clk);
        din = 1'b0;
        din_valid = 1'b0;
        pat_load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        din_valid = 1'b0;
        pat_load = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        din = 1'b1;
        din_valid = 1'b1;
        pat_load = 1'b0;
        #1;
        checks++;
        if (y !== 1'b0) begin
            errors++;
            $display("FAIL reset_y got %b exp 0", y);
        end
`ifdef SEQ_DETECT_CNT_EN
        checks++;
        if (match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d exp 0", match_cnt);
        end
`endif
        din_valid = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_overlap();
        logic [6:0] s = 7'b1101101;
        logic [6:0] e = 7'b0001001;
        logic o, o2;
        do_reset();
        overlap = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            drive(s[i], 1'b1, 1'b0, o, o2);
            checks++;
            if (o !== e[i]) begin
                errors++;
                $display("FAIL overlap_y bit%0d got %b exp %b", 7 - i, o, e[i]);
            end
        end
        idle();
`ifdef SEQ_DETECT_CNT_EN
        checks++;
        if (match_cnt !== 8'd2) begin
            errors++;
            $display("FAIL overlap_cnt got %0d exp 2", match_cnt);
        end
`endif
    endtask

    task automatic test_non_overlap();
        logic [6:0] s = 7'b1101101;
        logic [6:0] e = 7'b0001000;
        logic [7:0] s2 = 8'b11011101;
        logic [7:0] e2 = 8'b00010001;
        logic o, o2;
        do_reset();
        overlap = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            drive(s[i], 1'b1, 1'b0, o, o2);
            checks++;
            if (o !== e[i]) begin
                errors++;
                $display("FAIL nonovl_y bit%0d got %b exp %b", 7 - i, o, e[i]);
            end
        end
        idle();
`ifdef SEQ_DETECT_CNT_EN
        checks++;
        if (match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL nonovl_cnt got %0d exp 1", match_cnt);
        end
`endif
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            drive(s2[i], 1'b1, 1'b0, o, o2);
            checks++;
            if (o !== e2[i]) begin
                errors++;
                $display("FAIL nonovl2_y bit%0d got %b exp %b", 8 - i, o, e2[i]);
            end
        end
        idle();
        overlap = 1'b1;
    endtask

    task automatic test_pat_load();
        logic [6:0] s = 7'b0110110;
        logic [6:0] e = 7'b0001001;
        logic [2:0] pre = 3'b011;
        logic [3:0] post = 4'b0110;
        logic [3:0] epost = 4'b0001;
        logic o, o2;
        do_reset();
        overlap = 1'b1;
        pat_in = 4'b0110;
        drive(1'b0, 1'b0, 1'b1, o, o2);
        for (int i = 6; i >= 0; i--) begin
            drive(s[i], 1'b1, 1'b0, o, o2);
            checks++;
            if (o !== e[i]) begin
                errors++;
                $display("FAIL load_y bit%0d got %b exp %b", 7 - i, o, e[i]);
            end
        end
        for (int i = 2; i >= 0; i--) drive(pre[i], 1'b1, 1'b0, o, o2);
        // History 011 + din 0 would match, but the load must suppress it.
        drive(1'b0, 1'b1, 1'b1, o, o2);
        checks++;
        if (o !== 1'b0) begin
            errors++;
            $display("FAIL load_valid_y got %b exp 0", o);
        end
        for (int i = 3; i >= 0; i--) begin
            drive(post[i], 1'b1, 1'b0, o, o2);
            checks++;
            if (o !== epost[i]) begin
                errors++;
                $display("FAIL load_post_y bit%0d got %b exp %b", 4 - i, o, epost[i]);
            end
        end
        idle();
    endtask

    task automatic test_gapped();
        logic [3:0] s = 4'b1101;
        logic [3:0] e = 4'b0001;
        logic o, o2;
        do_reset();
        overlap = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            drive(s[i], 1'b1, 1'b0, o, o2);
            checks++;
            if (o !== e[i]) begin
                errors++;
                $display("FAIL gap_valid_y bit%0d got %b exp %b", 4 - i, o, e[i]);
            end
            drive(1'b1, 1'b0, 1'b0, o, o2);
            checks++;
            if (o !== 1'b0) begin
                errors++;
                $display("FAIL gap_idle_y after bit%0d got %b exp 0", 4 - i, o);
            end
        end
        idle();
    endtask

    task automatic test_saturate();
        logic [5:0] e = 6'b011111;
        logic o, o2;
        do_reset();
        overlap = 1'b1;
        for (int i = 5; i >= 0; i--) begin
            drive(1'b1, 1'b1, 1'b0, o, o2);
            checks++;
            if (o2 !== e[i]) begin
                errors++;
                $display("FAIL sat_y bit%0d got %b exp %b", 6 - i, o2, e[i]);
            end
        end
        idle();
`ifdef SEQ_DETECT_CNT_EN
        checks++;
        if (match_cnt2 !== 2'd3) begin
            errors++;
            $display("FAIL sat_cnt got %0d exp 3", match_cnt2);
        end
        drive(1'b1, 1'b1, 1'b0, o, o2);
        idle();
        checks++;
        if (match_cnt2 !== 2'd3) begin
            errors++;
            $display("FAIL sat_hold_cnt got %0d exp 3", match_cnt2);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [3:0] s = 4'b1101;
        logic [3:0] e = 4'b0001;
        logic o, o2;
        do_reset();
        overlap = 1'b1;
        drive(1'b1, 1'b1, 1'b0, o, o2);
        drive(1'b1, 1'b1, 1'b0, o, o2);
        drive(1'b0, 1'b1, 1'b0, o, o2);
        @(negedge clk);
        din = 1'b1;
        din_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (y !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async_y got %b exp 0", y);
        end
        din_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, o, o2);
        checks++;
        if (o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_first_y got %b exp 0", o);
        end
        for (int i = 3; i >= 0; i--) begin
            drive(s[i], 1'b1, 1'b0, o, o2);
            checks++;
            if (o !== e[i]) begin
                errors++;
                $display("FAIL rstmid_y bit%0d got %b exp %b", 4 - i, o, e[i]);
            end
        end
        idle();
`ifdef SEQ_DETECT_CNT_EN
        checks++;
        if (match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL rstmid_cnt got %0d exp 1", match_cnt);
        end
`endif
    endtask

    initial begin
        #20000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_pat_load();
        test_gapped();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
